fetch_unit: RTL and testbench

//  Instruction-fetch stage plus its output register. Drives the 16-bit instruction memory and

---
 rtl/fetch_pkg.sv | 22 ++
 rtl/fetch_unit.sv | 161 ++++++++++++++++
 tb/tb_fetch_unit.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/fetch_pkg.sv
// Shared fetch/decode definitions: FSM encoding, NOP, vector defaults and the
// two-word opcode test used by both fetch and the control unit.
package fetch_pkg;

    typedef enum logic [2:0] {
        ST_BOOT_HI   = 3'd0,
        ST_BOOT_LO   = 3'd1,
        ST_FETCH     = 3'd2,
        ST_FETCH_IMM = 3'd3,
        ST_VEC_HI    = 3'd4,
        ST_VEC_LO    = 3'd5
    } fetch_state_e;

    localparam logic [15:0] NOP              = 16'h0000;
    localparam logic [31:0] DEF_RST_VEC_ADDR = 32'd0;
    localparam logic [31:0] DEF_INT_VEC_ADDR = 32'd2;

    function automatic logic is_two_word(input logic [15:0] instr);
        return instr[15:14] == 2'b11;
    endfunction

endpackage

// File: rtl/fetch_unit.sv
// Instruction-fetch stage with output register: boot/interrupt vector loads,
// one/two-word assembly, stall/flush/jump handling and the interrupt bubble.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [31:0] RST_VEC_ADDR = DEF_RST_VEC_ADDR,
    parameter logic [31:0] INT_VEC_ADDR = DEF_INT_VEC_ADDR
) (
    input  logic        clk,
    input  logic        reset,
    output logic [31:0] imem_addr,
    input  logic [15:0] imem_data,
    input  logic        stall,
    input  logic        flush,
    input  logic        jmp_taken,
    input  logic [31:0] jmp_addr,
    input  logic        INT_req,
    output logic [31:0] PC_out,
    output logic [15:0] instruction_out,
    output logic [15:0] Data_out,
    output logic        INT_out,
    output logic        valid_out
);

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic [15:0]  hold_q, hold_d;
    logic         int_pend_q, int_pend_d;
    logic [31:0]  pc_out_q, pc_out_d;
    logic [15:0]  instr_q, instr_d;
    logic [15:0]  data_q, data_d;
    logic         int_out_q, int_out_d;
    logic         valid_q, valid_d;
    logic [31:0]  pc_inc;
    logic         in_body;

    assign pc_inc  = pc_q + 32'd1;
    assign in_body = (state_q == ST_FETCH) || (state_q == ST_FETCH_IMM);

    always_comb begin
        imem_addr = pc_q;
        case (state_q)
            ST_BOOT_HI: imem_addr = RST_VEC_ADDR;
            ST_BOOT_LO: imem_addr = RST_VEC_ADDR + 32'd1;
            ST_VEC_HI:  imem_addr = INT_VEC_ADDR;
            ST_VEC_LO:  imem_addr = INT_VEC_ADDR + 32'd1;
            default:    imem_addr = pc_q;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        hold_d     = hold_q;
        int_pend_d = int_pend_q | INT_req;
        pc_out_d   = pc_out_q;
        instr_d    = instr_q;
        data_d     = data_q;
        int_out_d  = int_out_q;
        valid_d    = valid_q;

        if (flush && in_body) begin
            // A pending interrupt in FETCH means no word was consumed yet.
            if (jmp_taken)
                pc_d = jmp_addr;
            else if (state_q == ST_FETCH && int_pend_q)
                pc_d = pc_q;
            else
                pc_d = pc_inc;
            state_d   = ST_FETCH;
            hold_d    = '0;
            pc_out_d  = '0;
            instr_d   = NOP;
            data_d    = '0;
            int_out_d = 1'b0;
            valid_d   = 1'b0;
        end else if (!stall) begin
            pc_out_d  = '0;
            instr_d   = NOP;
            data_d    = '0;
            int_out_d = 1'b0;
            valid_d   = 1'b0;
            case (state_q)
                ST_BOOT_HI: begin
                    hold_d  = imem_data;
                    state_d = ST_BOOT_LO;
                end
                ST_BOOT_LO: begin
                    pc_d    = {hold_q, imem_data};
                    state_d = ST_FETCH;
                end
                ST_FETCH: begin
                    if (int_pend_q) begin
                        pc_out_d   = pc_q;
                        int_out_d  = 1'b1;
                        valid_d    = 1'b1;
                        int_pend_d = 1'b0;
                        state_d    = ST_VEC_HI;
                    end else if (is_two_word(imem_data)) begin
                        hold_d  = imem_data;
                        pc_d    = pc_inc;
                        state_d = ST_FETCH_IMM;
                    end else begin
                        instr_d  = imem_data;
                        pc_out_d = pc_inc;
                        valid_d  = 1'b1;
                        pc_d     = pc_inc;
                    end
                end
                ST_FETCH_IMM: begin
                    instr_d  = hold_q;
                    data_d   = imem_data;
                    pc_out_d = pc_inc;
                    valid_d  = 1'b1;
                    pc_d     = pc_inc;
                    state_d  = ST_FETCH;
                end
                ST_VEC_HI: begin
                    hold_d  = imem_data;
                    state_d = ST_VEC_LO;
                end
                ST_VEC_LO: begin
                    pc_d    = {hold_q, imem_data};
                    state_d = ST_FETCH;
                end
                default: state_d = ST_BOOT_HI;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_BOOT_HI;
            pc_q       <= '0;
            hold_q     <= '0;
            int_pend_q <= 1'b0;
            pc_out_q   <= '0;
            instr_q    <= '0;
            data_q     <= '0;
            int_out_q  <= 1'b0;
            valid_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            hold_q     <= hold_d;
            int_pend_q <= int_pend_d;
            pc_out_q   <= pc_out_d;
            instr_q    <= instr_d;
            data_q     <= data_d;
            int_out_q  <= int_out_d;
            valid_q    <= valid_d;
        end
    end

    assign PC_out          = pc_out_q;
    assign instruction_out = instr_q;
    assign Data_out        = data_q;
    assign INT_out         = int_out_q;
    assign valid_out       = valid_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: directed program in a small memory model,
// expected slots queued by the stimulus and popped by a monitor on valid_out.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] imem_addr;
    logic [15:0] imem_data;
    logic        stall, flush, jmp_taken, INT_req;
    logic [31:0] jmp_addr;
    logic [31:0] PC_out;
    logic [15:0] instruction_out, Data_out;
    logic        INT_out, valid_out;

    typedef struct {
        logic [31:0] pc;
        logic [15:0] ins;
        logic [15:0] dat;
        logic        irq;
    } exp_t;

    exp_t        exp_q[$];
    logic [15:0] mem [256];
    int          checks = 0;
    int          errors = 0;
    logic        done = 1'b0;

    fetch_unit #(.RST_VEC_ADDR(32'd0), .INT_VEC_ADDR(32'd2)) dut (
        .clk(clk), .reset(reset), .imem_addr(imem_addr), .imem_data(imem_data),
        .stall(stall), .flush(flush), .jmp_taken(jmp_taken), .jmp_addr(jmp_addr),
        .INT_req(INT_req), .PC_out(PC_out), .instruction_out(instruction_out),
        .Data_out(Data_out), .INT_out(INT_out), .valid_out(valid_out)
    );

    always #5 clk = ~clk;

    assign imem_data = (imem_addr[31:8] == '0) ? mem[imem_addr[7:0]] : 16'h0000;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
        end
    endtask

    task automatic push(input logic [31:0] pc, input logic [15:0] ins,
                        input logic [15:0] dat, input logic irq);
        exp_t e;
        e.pc = pc; e.ins = ins; e.dat = dat; e.irq = irq;
        exp_q.push_back(e);
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_addr(input logic [31:0] a);
        int unsigned n = 0;
        while (imem_addr !== a && n < 300) begin
            tick();
            n++;
        end
        chk("wait_addr", imem_addr, a);
    endtask

    task automatic boot_check();
        chk("boot_c1_addr", imem_addr, 32'h0);
        chk("boot_c1_valid", {31'b0, valid_out}, 32'h0);
        tick();
        chk("boot_c2_addr", imem_addr, 32'h1);
        chk("boot_c2_valid", {31'b0, valid_out}, 32'h0);
        tick();
        chk("boot_c3_addr", imem_addr, 32'h10);
    endtask

    // Monitor: every valid slot must match the oldest queued expectation.
    always @(negedge clk) begin
        if (!done && valid_out === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_slot: got pc=%h ins=%h dat=%h int=%b expected none",
                         PC_out, instruction_out, Data_out, INT_out);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                checks++;
                if (PC_out !== e.pc || instruction_out !== e.ins ||
                    Data_out !== e.dat || INT_out !== e.irq) begin
                    errors++;
                    $display("FAIL slot: got pc=%h ins=%h dat=%h int=%b expected pc=%h ins=%h dat=%h int=%b",
                             PC_out, instruction_out, Data_out, INT_out, e.pc, e.ins, e.dat, e.irq);
                end
            end
        end
    end

    initial begin
        for (int unsigned i = 0; i < 256; i++) mem[i] = 16'h0000;
        mem[0]  = 16'h0000; mem[1]  = 16'h0010;
        mem[2]  = 16'h0000; mem[3]  = 16'h0030;
        mem[16] = 16'h1111; mem[17] = 16'hC123; mem[18] = 16'h5A5A;
        mem[19] = 16'h2222; mem[20] = 16'hC777; mem[21] = 16'h0BEE;
        mem[8'h30] = 16'h3333; mem[8'h31] = 16'h4444; mem[8'h32] = 16'h5555;
        mem[8'h33] = 16'hC0AA; mem[8'h34] = 16'h1234;
        mem[8'h35] = 16'hC0BB; mem[8'h36] = 16'h9999;
        mem[8'h37] = 16'h0777;
        mem[8'h38] = 16'hC888; mem[8'h39] = 16'h0999;
        mem[8'h40] = 16'h0040;

        reset = 1'b1; stall = 1'b0; flush = 1'b0; jmp_taken = 1'b0;
        jmp_addr = '0; INT_req = 1'b0;
        tick(); tick();
        chk("rst_addr", imem_addr, 32'h0);
        chk("rst_valid", {31'b0, valid_out}, 32'h0);
        chk("rst_pc_out", PC_out, 32'h0);
        reset = 1'b0;
        boot_check();

        // Mixed stream and interrupt during the immediate word.
        push(32'h11, 16'h1111, 16'h0000, 1'b0);
        push(32'h13, 16'hC123, 16'h5A5A, 1'b0);
        push(32'h14, 16'h2222, 16'h0000, 1'b0);
        push(32'h16, 16'hC777, 16'h0BEE, 1'b0);
        push(32'h16, 16'h0000, 16'h0000, 1'b1);
        push(32'h31, 16'h3333, 16'h0000, 1'b0);
        push(32'h32, 16'h4444, 16'h0000, 1'b0);
        push(32'h33, 16'h5555, 16'h0000, 1'b0);
        wait_addr(32'd21);
        INT_req = 1'b1;
        tick();
        INT_req = 1'b0;

        // Jump coinciding with a pending interrupt.
        wait_addr(32'h32);
        INT_req = 1'b1;
        tick();
        INT_req = 1'b0;
        flush = 1'b1; jmp_taken = 1'b1; jmp_addr = 32'h40;
        tick();
        flush = 1'b0; jmp_taken = 1'b0;
        chk("jmp_bubble_valid", {31'b0, valid_out}, 32'h0);
        chk("jmp_addr_issued", imem_addr, 32'h40);
        push(32'h40, 16'h0000, 16'h0000, 1'b1);
        push(32'h31, 16'h3333, 16'h0000, 1'b0);
        push(32'h32, 16'h4444, 16'h0000, 1'b0);
        push(32'h33, 16'h5555, 16'h0000, 1'b0);
        push(32'h35, 16'hC0AA, 16'h1234, 1'b0);

        // Stall three cycles between the two words.
        wait_addr(32'h34);
        stall = 1'b1;
        for (int unsigned i = 0; i < 3; i++) begin
            tick();
            chk("stall_addr", imem_addr, 32'h34);
            chk("stall_valid", {31'b0, valid_out}, 32'h0);
        end
        stall = 1'b0;

        // Flush without jump during FETCH_IMM drops the held word.
        wait_addr(32'h36);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("flush_valid", {31'b0, valid_out}, 32'h0);
        chk("flush_next_addr", imem_addr, 32'h37);
        push(32'h38, 16'h0777, 16'h0000, 1'b0);
        push(32'h3A, 16'hC888, 16'h0999, 1'b0);
        push(32'h3A, 16'h0000, 16'h0000, 1'b1);

        // Reset mid vector load, then re-boot.
        wait_addr(32'h38);
        INT_req = 1'b1;
        tick();
        INT_req = 1'b0;
        wait_addr(32'h3);
        #2 reset = 1'b1;
        #1;
        chk("async_rst_addr", imem_addr, 32'h0);
        chk("async_rst_valid", {31'b0, valid_out}, 32'h0);
        chk("async_rst_int", {31'b0, INT_out}, 32'h0);
        tick(); tick();
        chk("queue_before_reboot", exp_q.size(), 32'd0);
        reset = 1'b0;
        boot_check();
        push(32'h11, 16'h1111, 16'h0000, 1'b0);
        push(32'h13, 16'hC123, 16'h5A5A, 1'b0);
        push(32'h14, 16'h2222, 16'h0000, 1'b0);

        begin
            int unsigned n = 0;
            while (exp_q.size() != 0 && n < 100) begin
                tick();
                n++;
            end
        end
        done = 1'b1;
        chk("queue_drained", exp_q.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
